// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel PWM with shared prescaler, boundary-latched
// duty registers, optional servo threshold mapping and phase staggering.
module pwm_multichannel #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 3,
  parameter int PRESCALE_W  = 24,
  parameter int SERVO_BASE  = 13,
  parameter int SERVO_SHIFT = 4,
  parameter int STAGGER     = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  mode_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  wr_en_i,
  input  logic [CW-1:0]         wr_ch_i,
  input  logic [WIDTH-1:0]      wr_duty_i,
  output logic [CHANNELS-1:0]   pwm_o,
  output logic                  period_o
);

  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [CW:0]      CH_N = (CW+1)'(CHANNELS);

  logic [PRESCALE_W-1:0] q_q, q_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      pend_q [CHANNELS];
  logic [WIDTH-1:0]      pend_d [CHANNELS];
  logic [WIDTH-1:0]      act_q  [CHANNELS];
  logic [WIDTH-1:0]      act_d  [CHANNELS];
  logic                  mode_q, mode_d;
  logic                  en_q;
  logic                  bnd_q, bnd_d;
  logic [CHANNELS-1:0]   pwm_q, pwm_d;
  logic                  per_q, per_d;

  logic tick;
  logic start;
  logic load;
  logic wr_ok;
  logic mode_eff;

  assign wr_ok    = wr_en_i && ({1'b0, wr_ch_i} < CH_N);
  assign tick     = enable_i && (q_q >= prescale_i);
  assign start    = enable_i && !en_q;
  assign load     = start || (tick && (cnt_q == CMAX));
  assign mode_eff = start ? mode_i : mode_q;

  always_comb begin
    q_d   = '0;
    cnt_d = '0;
    if (enable_i) begin
      q_d   = tick ? '0 : q_q + 1'b1;
      cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    end
    mode_d = load ? mode_i : mode_q;
    bnd_d  = tick && (cnt_q == CMAX);
    per_d  = enable_i && bnd_q;
    for (int k = 0; k < CHANNELS; k++) begin
      pend_d[k] = pend_q[k];
      if (wr_ok && (wr_ch_i == CW'(k)))
        pend_d[k] = wr_duty_i;
      // a write on the load cycle goes straight to active
      act_d[k] = load ? pend_d[k] : act_q[k];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [WIDTH-1:0] OFF =
      WIDTH'(STAGGER * k * ((2 ** WIDTH) / CHANNELS));
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] ph;
    logic [WIDTH:0]   thr;

    assign duty = start ? act_d[k] : act_q[k];
    assign ph   = cnt_q + OFF;

    always_comb begin
      thr = {1'b0, duty};
      if (mode_eff)
        thr = (WIDTH+1)'(SERVO_BASE) + (WIDTH+1)'(duty >> SERVO_SHIFT);
    end

    assign pwm_d[k] = enable_i && ({1'b0, ph} < thr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      en_q   <= 1'b0;
      bnd_q  <= 1'b0;
      pwm_q  <= '0;
      per_q  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        pend_q[k] <= '0;
        act_q[k]  <= '0;
      end
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      en_q   <= enable_i;
      bnd_q  <= bnd_d;
      pwm_q  <= pwm_d;
      per_q  <= per_d;
      for (int k = 0; k < CHANNELS; k++) begin
        pend_q[k] <= pend_d[k];
        act_q[k]  <= act_d[k];
      end
    end
  end

  assign pwm_o    = pwm_q;
  assign period_o = per_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed checks of duty, servo, stagger, prescale,
// reset and enable behaviour on two instances (STAGGER 0 and 1).
module tb_pwm_multichannel;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [23:0] ps;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_duty;
  logic [2:0]  pwm0, pwm1;
  logic        per0, per1;

  int n_cmp = 0;
  int n_bad = 0;
  int hi0 [3];
  int hi1 [3];
  int rise1 [3];
  int len;

  always #5 clk = ~clk;

  pwm_multichannel #(.STAGGER(0)) u0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .mode_i(mode),
    .prescale_i(ps), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
    .wr_duty_i(wr_duty), .pwm_o(pwm0), .period_o(per0)
  );

  pwm_multichannel #(.STAGGER(1)) u1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .mode_i(mode),
    .prescale_i(ps), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
    .wr_duty_i(wr_duty), .pwm_o(pwm1), .period_o(per1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_duty = 8'(d);
  endtask

  task automatic wr(input int ch, input int d);
    drive(ch, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_per(input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (per0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("wait_period", 0, 1);
  endtask

  // Starts on a period_o sample, ends on the next one.
  task automatic run_period(input int limit, input int hook);
    len = 0;
    for (int k = 0; k < 3; k++) begin
      hi0[k] = 0; hi1[k] = 0; rise1[k] = -1;
    end
    forever begin
      for (int k = 0; k < 3; k++) begin
        if (pwm0[k]) hi0[k]++;
        if (pwm1[k]) begin
          hi1[k]++;
          if (rise1[k] < 0) rise1[k] = len;
        end
      end
      wr_en = 1'b0;
      if (hook == 1 && len == 254) drive(1, 200);
      if (hook == 1 && len == 255) drive(1, 50);
      if (hook == 2 && len == 6) ps = 24'd2;
      if (hook == 3 && len == 10) drive(3, 7);
      if (hook == 4 && len == 20) drive(0, 255);
      if (hook == 4 && len == 21) drive(1, 0);
      len++;
      @(negedge clk);
      if (per0) break;
      if (len >= limit) begin
        chk("period_timeout", len, -1);
        break;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic chk_hi(input string tag, input int e0, input int e1,
                        input int e2);
    chk({tag, "_ch0"}, hi0[0], e0);
    chk({tag, "_ch1"}, hi0[1], e1);
    chk({tag, "_ch2"}, hi0[2], e2);
  endtask

  initial begin
    int cnt_hi;
    int cnt_per;
    rst = 1'b1; en = 1'b1; mode = 1'b0; ps = '0;
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd99;
    repeat (3) @(negedge clk);
    chk("rst_pwm0", int'(pwm0), 0);
    chk("rst_per0", int'(per0), 0);
    chk("rst_pwm1", int'(pwm1), 0);
    rst = 1'b0; wr_en = 1'b0;

    wait_per(600);
    run_period(300, 0);
    chk("p0_len", len, 256);
    chk_hi("p0", 0, 0, 0);

    wr(0, 64); wr(1, 128); wr(2, 255);
    wait_per(600);
    run_period(300, 0);
    chk("lin_len", len, 256);
    chk_hi("lin", 64, 128, 255);

    run_period(300, 1);
    chk_hi("bwr_cur", 64, 128, 255);
    run_period(300, 3);
    chk_hi("bwr_200", 64, 200, 255);
    run_period(300, 0);
    chk_hi("bwr_50", 64, 50, 255);

    wr(0, 85); wr(1, 85); wr(2, 85);
    wait_per(600);
    chk("stag_per1", int'(per1), 1);
    run_period(300, 0);
    chk_hi("stag_u0", 85, 85, 85);
    for (int k = 0; k < 3; k++)
      chk($sformatf("stag_u1_hi%0d", k), hi1[k], 85);
    chk("stag_rise0", rise1[0], 0);
    chk("stag_rise1", rise1[1], 171);
    chk("stag_rise2", rise1[2], 86);

    mode = 1'b1;
    run_period(300, 0);
    chk_hi("srv_defer", 85, 85, 85);
    run_period(300, 4);
    chk_hi("srv_85", 18, 18, 18);
    run_period(300, 0);
    chk_hi("srv_ends", 28, 13, 18);

    mode = 1'b0; ps = 24'd9;
    wr(0, 10);
    wait_per(3000);
    run_period(3000, 0);
    chk("ps9_len", len, 2560);
    chk_hi("ps9", 100, 0, 850);
    run_period(1000, 2);
    chk("ps_drop_len", len, 773);
    chk("ps_drop_hi", hi0[0], 35);
    run_period(1000, 0);
    chk("ps2_len", len, 768);
    chk("ps2_hi", hi0[0], 30);

    ps = '0;
    wr(0, 128);
    wait_per(1000);
    repeat (50) @(negedge clk);
    chk("pre_rst_hi", int'(pwm0[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pwm", int'(pwm0), 0);
    chk("midrst_per", int'(per0), 0);
    rst = 1'b0;
    wait_per(600);
    run_period(300, 0);
    chk("post_rst_len", len, 256);
    chk_hi("post_rst", 0, 0, 0);

    wr(0, 40);
    wait_per(600);
    run_period(300, 0);
    chk_hi("pre_dis", 40, 0, 0);
    repeat (30) @(negedge clk);
    en = 1'b0;
    wr(1, 100); wr(2, 200);
    cnt_hi = 0; cnt_per = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm0 != 3'b000) cnt_hi++;
      if (per0) cnt_per++;
    end
    chk("dis_pwm", cnt_hi, 0);
    chk("dis_per", cnt_per, 0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) hi0[k] = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (pwm0[k]) hi0[k]++;
    end
    chk_hi("en_first", 40, 100, 200);
    @(negedge clk);
    chk("en_wrap_per", int'(per0), 1);
    run_period(300, 0);
    chk("en_len", len, 256);
    chk_hi("en_second", 40, 100, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator with a shared programmable prescaler, per-channel duty registers that update glitch-free at period boundaries, an optional servo-mapping mode and optional phase staggering between channels. It drives LED and servo outputs directly from the top-level tile, with duty values written over a simple single-cycle write port from the control logic.

## Interface
- WIDTH, 8, duty and period counter width; the period is 2^WIDTH ticks
- CHANNELS, 3, number of PWM outputs (≥1)
- PRESCALE_W, 24, prescaler counter width
- SERVO_BASE, 13, servo-mode threshold offset, in ticks
- SERVO_SHIFT, 4, servo-mode right shift applied to duty
- STAGGER, 0, 1 = channel k phase-offset by k·(2^WIDTH/CHANNELS) ticks
- clk_i  in  1  system clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  1 = run; 0 = counters held at 0, outputs low
- mode_i  in  1  0 = linear PWM, 1 = servo mapping
- prescale_i  in  PRESCALE_W  tick every prescale_i+1 clocks
- wr_en_i  in  1  duty write strobe, one clock per write
- wr_ch_i  in  max(1,$clog2(CHANNELS))  target channel
- wr_duty_i  in  WIDTH  duty value
- pwm_o  out  CHANNELS  registered PWM outputs
- period_o  out  1  one-clock pulse at each period start

## Operation
- State: prescaler q[PRESCALE_W], period counter cnt[WIDTH], pending[CHANNELS][WIDTH], active[CHANNELS][WIDTH], mode_act.
- Prescaler: each clock with enable_i=1, if q ≥ prescale_i then q←0 and tick=1, else q←q+1. The ≥ comparison lets a reduced prescale_i take effect without a long wrap.
- Period counter: on tick, cnt←cnt+1 and wraps modulo 2^WIDTH. A boundary is a tick with cnt = 2^WIDTH−1.
- Write: when wr_en_i=1 and wr_ch_i < CHANNELS, pending[wr_ch_i]←wr_duty_i. Out-of-range channels are ignored. Writes are accepted whatever the value of enable_i.
- Boundary load: at a boundary, active[k]←pending[k] for all k and mode_act←mode_i.
  - If a write hits the boundary cycle, the written value bypasses pending and lands in active for that channel.
- Threshold:
  - mode_act=0: thr_k = active[k].
  - mode_act=1: thr_k = SERVO_BASE + (active[k] >> SERVO_SHIFT), computed WIDTH+1 bits wide with no truncation.
- Phase: ph_k = (cnt + STAGGER·k·(2^WIDTH/CHANNELS)) mod 2^WIDTH, with integer division.
- Output: pwm_o[k] ← enable_i & (ph_k < thr_k), registered.
  - Duty 0 gives a constant low output.
  - Duty 2^WIDTH−1 gives a high time of (2^WIDTH−1)/2^WIDTH. 100% is not reachable.
- Disable: with enable_i=0, q, cnt, pwm_o and period_o are forced to 0 every clock.
  - On the first clock with enable_i=1, active←pending and mode_act←mode_i, so the first period is immediately correct.

## Timing
- Reset values: q=0, cnt=0, pending=0, active=0, mode_act=0, pwm_o=0, period_o=0.
- Reset wins over every other input in the same cycle.
- Reset mid-period: outputs are low on the next clock, and the next period starts from cnt=0 with duty 0 until new writes arrive.
- Latency:
  - cnt change → pwm_o change: 1 clock.
  - A duty write becomes visible from the first period starting after the next boundary, with a worst case of one full period plus 1 clock.
- period_o is high for exactly one clock, in the clock after cnt wraps to 0. It is registered alongside pwm_o, so the pulse aligns with the first clock of the new period on pwm_o.
- The period in clocks is (prescale_i+1)·2^WIDTH.
  - prescale_i=0 gives a tick every clock.
- mode_i and duty changes never alter pwm_o within a period, so there are no runt pulses.
- Changes to prescale_i are used immediately and may stretch or shorten the current tick.

## Test plan
- Default parameters, prescale_i=0, enable_i=1, write ch0=64, ch1=128, ch2=255 → from the second period: ch0 high 64 of 256 clocks, ch1 high 128, ch2 high 255. period_o pulses every 256 clocks.
- mode_i=1, ch0 duty=255 → thr=13+15=28, so 28 high clocks per period. Duty 0 → 13 high clocks. The mode switch applies only at the next boundary.
- Write ch1=200 on the exact boundary cycle, then 50 one clock later → the next period shows 200 high clocks and the following period shows 50. A write with wr_ch_i=3 changes nothing.
- STAGGER=1, all duties=85 → ch0 rises at cnt=0, ch1 at cnt=171, ch2 at cnt=86. Each channel is high for 85 clocks, with a cyclic rise offset of 85 clocks between consecutive channels.
- prescale_i=9, duty=10 → period of 2560 clocks with 100 high. Drop prescale_i to 2 while q=7 → a tick on the next clock and no long stall.
- Assert rst_i mid-period with ch0=128 → pwm_o=0 and period_o=0 on the next clock; after release, outputs stay low until duty is rewritten. Toggle enable_i 1→0→1 → outputs low while disabled and correct from the first enabled period.
